test_status_sequencer: RTL and testbench

//  Serialises firmware test verdicts onto the two user-GPIO status pins the test benches sample:

---
 rtl/test_status_pkg.sv | 31 +++
 rtl/status_fifo.sv | 68 ++++++
 rtl/test_status_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_test_status_sequencer.sv | 456 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/test_status_pkg.sv
// Shared types for the test status sequencer: FSM states, verdict payload and
// elaboration-time sizing helpers.
package test_status_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_PULSE = 2'd2,
      ST_GAP   = 2'd3
   } seq_state_e;

   // One firmware verdict as stored in the FIFO.
   typedef struct packed {
      logic pass;
      logic last;
   } verdict_t;

   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // Bits needed for a down-counter loaded with at most max_cycles-1.
   function automatic int unsigned timer_bits(input int unsigned max_cycles);
      return (max_cycles < 2) ? 1 : $clog2(max_cycles);
   endfunction

endpackage

// File: rtl/status_fifo.sv
// Synchronous verdict FIFO with wrap-bit pointers.
// Ports:
//   wb_clk_i, wb_rst_n       clock, synchronous active-low reset
//   wr_en, wr_data           write request and payload
//   rd_en                    pop the head entry
//   rd_data_c                head entry (combinational view of storage)
//   empty_c, full_c          current occupancy flags
//   empty_nx_c, full_nx_c    occupancy flags after this edge's push/pop
module status_fifo
   import test_status_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic     wb_clk_i,
   input  logic     wb_rst_n,
   input  logic     wr_en,
   input  verdict_t wr_data,
   input  logic     rd_en,
   output verdict_t rd_data_c,
   output logic     empty_c,
   output logic     full_c,
   output logic     empty_nx_c,
   output logic     full_nx_c
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [PW-1:0] wr_ptr_nx, rd_ptr_nx;
   verdict_t      mem_q [DEPTH];
   logic          do_wr, do_rd;

   // A write into a full FIFO is only taken when the head leaves on the same edge.
   assign do_wr = wr_en && (!full_c || rd_en);
   assign do_rd = rd_en && !empty_c;

   assign wr_ptr_nx = wr_ptr_q + PW'(do_wr);
   assign rd_ptr_nx = rd_ptr_q + PW'(do_rd);

   assign empty_c    = (wr_ptr_q == rd_ptr_q);
   assign full_c     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_nx_c = (wr_ptr_nx == rd_ptr_nx);
   assign full_nx_c  = (wr_ptr_nx[AW] != rd_ptr_nx[AW]) &&
                       (wr_ptr_nx[AW-1:0] == rd_ptr_nx[AW-1:0]);

   assign rd_data_c = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer registers.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_nx;
         rd_ptr_q <= rd_ptr_nx;
      end
   end

   // Storage; contents are don't-care until written.
   always_ff @(posedge wb_clk_i) begin
      if (do_wr) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: rtl/test_status_sequencer.sv
// Serialises firmware test verdicts onto the success/next_test status pins.
// A FIFO absorbs bursts; the FSM presents success, pulses next_test, then
// leaves a gap before the next verdict. Keeps pass/fail counts and flags.
// Ports:
//   wb_clk_i, wb_rst_n         clock, synchronous active-low reset
//   push_valid/ready           verdict handshake (transfer on valid && ready)
//   push_pass, push_last       verdict payload
//   success_o, next_test_o     status pins (straight from flops)
//   busy_o                     FIFO non-empty or FSM active
//   sticky_fail_o, done_o      sticky flags, cleared only by reset
//   pass_cnt_o, fail_cnt_o     saturating emitted-verdict counters
module test_status_sequencer
   import test_status_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter int unsigned SETUP_CYCLES = 8,
   parameter int unsigned PULSE_CYCLES = 16,
   parameter int unsigned GAP_CYCLES   = 16,
   parameter bit          STOP_ON_FAIL = 1'b1,
   parameter int unsigned CNT_W        = 8
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_n,
   input  logic             push_valid,
   output logic             push_ready,
   input  logic             push_pass,
   input  logic             push_last,
   output logic             success_o,
   output logic             next_test_o,
   output logic             busy_o,
   output logic             sticky_fail_o,
   output logic             done_o,
   output logic [CNT_W-1:0] pass_cnt_o,
   output logic [CNT_W-1:0] fail_cnt_o
);

   localparam int unsigned MAX_CYC = max3(SETUP_CYCLES, PULSE_CYCLES, GAP_CYCLES);
   localparam int unsigned TW      = timer_bits(MAX_CYC);

   localparam logic [TW-1:0] SETUP_LOAD = TW'(SETUP_CYCLES - 1);
   localparam logic [TW-1:0] PULSE_LOAD = TW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

   seq_state_e       state_q, state_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic             last_q, last_d;
   logic             success_q, success_d;
   logic             next_test_q, next_test_d;
   logic             sticky_q, sticky_d;
   logic             done_q, done_d;
   logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
   logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;

   logic     pop, discard, wr_en;
   verdict_t push_v, head_c;
   logic     fifo_empty_c, fifo_full_c, fifo_empty_nx_c, fifo_full_nx_c;

   assign push_v = '{pass: push_pass, last: push_last};
   assign wr_en  = push_valid && ready_q;

   status_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_n   (wb_rst_n),
      .wr_en      (wr_en),
      .wr_data    (push_v),
      .rd_en      (pop),
      .rd_data_c  (head_c),
      .empty_c    (fifo_empty_c),
      .full_c     (fifo_full_c),
      .empty_nx_c (fifo_empty_nx_c),
      .full_nx_c  (fifo_full_nx_c)
   );

   // Next-state, timer, flags and counters.
   always_comb begin
      state_d     = state_q;
      tmr_d       = tmr_q;
      last_d      = last_q;
      success_d   = success_q;
      next_test_d = next_test_q;
      sticky_d    = sticky_q;
      done_d      = done_q;
      pass_cnt_d  = pass_cnt_q;
      fail_cnt_d  = fail_cnt_q;
      pop         = 1'b0;
      discard     = (STOP_ON_FAIL && sticky_q) || done_q;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty_c) begin
               pop = 1'b1;
               if (!discard) begin
                  success_d = head_c.pass;
                  last_d    = head_c.last;
                  tmr_d     = SETUP_LOAD;
                  state_d   = ST_SETUP;
               end
            end
         end
         ST_SETUP: begin
            if (tmr_q == '0) begin
               next_test_d = 1'b1;
               tmr_d       = PULSE_LOAD;
               state_d     = ST_PULSE;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         ST_PULSE: begin
            if (tmr_q == '0) begin
               next_test_d = 1'b0;
               tmr_d       = GAP_LOAD;
               state_d     = ST_GAP;
               // The verdict counts as emitted on the falling edge of the pulse.
               if (success_q) begin
                  if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_W'(1);
               end else begin
                  sticky_d = 1'b1;
                  if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + CNT_W'(1);
               end
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         ST_GAP: begin
            if (tmr_q == '0) begin
               state_d = ST_IDLE;
               if (last_q) done_d = 1'b1;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d  = !fifo_empty_nx_c || (state_d != ST_IDLE);
      // Ready for next cycle: room in the FIFO, or the head is popped on that same edge.
      ready_d = !fifo_full_nx_c || ((state_d == ST_IDLE) && !fifo_empty_nx_c);
   end

   // State and output registers.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) begin
         state_q     <= ST_IDLE;
         tmr_q       <= '0;
         last_q      <= 1'b0;
         success_q   <= 1'b0;
         next_test_q <= 1'b0;
         sticky_q    <= 1'b0;
         done_q      <= 1'b0;
         pass_cnt_q  <= '0;
         fail_cnt_q  <= '0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         last_q      <= last_d;
         success_q   <= success_d;
         next_test_q <= next_test_d;
         sticky_q    <= sticky_d;
         done_q      <= done_d;
         pass_cnt_q  <= pass_cnt_d;
         fail_cnt_q  <= fail_cnt_d;
         busy_q      <= busy_d;
         ready_q     <= ready_d;
      end
   end

   assign push_ready    = ready_q;
   assign success_o     = success_q;
   assign next_test_o   = next_test_q;
   assign busy_o        = busy_q;
   assign sticky_fail_o = sticky_q;
   assign done_o        = done_q;
   assign pass_cnt_o    = pass_cnt_q;
   assign fail_cnt_o    = fail_cnt_q;

endmodule

// File: tb/tb_test_status_sequencer.sv
// Directed bench for test_status_sequencer: instance A stops on fail, instance B does not.
module tb_test_status_sequencer;

   logic clk;
   logic rst_n;
   logic v, p, l;
   logic sel;

   logic       va, vb;
   logic       rdy_a, succ_a, nt_a, busy_a, stk_a, done_a;
   logic       rdy_b, succ_b, nt_b, busy_b, stk_b, done_b;
   logic [7:0] pc_a, fc_a, pc_b, fc_b;

   logic       o_ready, o_succ, o_nt, o_busy, o_sticky, o_done;
   logic [7:0] o_pc, o_fc;

   int errors;
   int checks;

   // Burst recorder results.
   int   nrise;
   int   rise_cyc [8];
   logic rise_succ [8];
   int   bad_width;
   int   nxfer;
   int   xfer_cyc [8];
   logic rdy_after [8];
   bit   ready_dropped;
   bit   timeout;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign va = v & ~sel;
   assign vb = v & sel;

   assign o_ready  = sel ? rdy_b  : rdy_a;
   assign o_succ   = sel ? succ_b : succ_a;
   assign o_nt     = sel ? nt_b   : nt_a;
   assign o_busy   = sel ? busy_b : busy_a;
   assign o_sticky = sel ? stk_b  : stk_a;
   assign o_done   = sel ? done_b : done_a;
   assign o_pc     = sel ? pc_b   : pc_a;
   assign o_fc     = sel ? fc_b   : fc_a;

   test_status_sequencer #(.STOP_ON_FAIL(1'b1)) dut_a (
      .wb_clk_i      (clk),
      .wb_rst_n      (rst_n),
      .push_valid    (va),
      .push_ready    (rdy_a),
      .push_pass     (p),
      .push_last     (l),
      .success_o     (succ_a),
      .next_test_o   (nt_a),
      .busy_o        (busy_a),
      .sticky_fail_o (stk_a),
      .done_o        (done_a),
      .pass_cnt_o    (pc_a),
      .fail_cnt_o    (fc_a)
   );

   test_status_sequencer #(.STOP_ON_FAIL(1'b0)) dut_b (
      .wb_clk_i      (clk),
      .wb_rst_n      (rst_n),
      .push_valid    (vb),
      .push_ready    (rdy_b),
      .push_pass     (p),
      .push_last     (l),
      .success_o     (succ_b),
      .next_test_o   (nt_b),
      .busy_o        (busy_b),
      .sticky_fail_o (stk_b),
      .done_o        (done_b),
      .pass_cnt_o    (pc_b),
      .fail_cnt_o    (fc_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      v     = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Pushes n verdicts (pass bit k of pb, last=0) with valid held, records pulses.
   task automatic run_burst(input int n, input logic [5:0] pb, input int budget);
      int   k;
      int   cyc;
      int   hi;
      bit   xfer;
      logic nt_prev;
      k = 0; cyc = 0; hi = 0;
      nrise = 0; bad_width = 0; nxfer = 0; ready_dropped = 0; timeout = 0;
      nt_prev = o_nt;
      while (1) begin
         if (k < n) begin
            v = 1'b1; p = pb[k]; l = 1'b0;
         end else begin
            v = 1'b0;
         end
         xfer = (k < n) && (o_ready === 1'b1);
         if (k < n && o_ready !== 1'b1) ready_dropped = 1;
         tick();
         cyc++;
         if (xfer) begin
            xfer_cyc[k]  = cyc;
            rdy_after[k] = o_ready;
            k++;
         end
         if (o_nt === 1'b1 && nt_prev !== 1'b1) begin
            if (nrise < 8) begin
               rise_cyc[nrise]  = cyc;
               rise_succ[nrise] = o_succ;
            end
            nrise++;
            hi = 1;
         end else if (o_nt === 1'b1) begin
            hi++;
         end else if (nt_prev === 1'b1 && hi != 16) begin
            bad_width++;
         end
         nt_prev = o_nt;
         if (k >= n && o_busy === 1'b0) break;
         if (cyc >= budget) begin
            timeout = 1;
            break;
         end
      end
      v = 1'b0;
      nxfer = k;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; v = 1'b0;
      tick();
      tick();
      for (int s = 0; s < 2; s++) begin
         sel = (s == 1);
         #1;
         checks++;
         if ({o_ready, o_succ, o_nt, o_busy, o_sticky, o_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags[%0d]: got %b expected 000000", s,
                     {o_ready, o_succ, o_nt, o_busy, o_sticky, o_done});
         end
         checks++;
         if ({o_pc, o_fc} !== 16'h0) begin
            errors++;
            $display("FAIL reset_counts[%0d]: got %h expected 0000", s, {o_pc, o_fc});
         end
      end
      rst_n = 1'b1;
      tick();
      for (int s = 0; s < 2; s++) begin
         sel = (s == 1);
         #1;
         checks++;
         if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release[%0d]: got %b expected 1", s, o_ready);
         end
      end
      sel = 1'b0;
      #1;
   endtask

   // One pass verdict with last=1 into an idle, freshly reset instance.
   task automatic single_pass(input string tag);
      int n;
      int w;
      int g;
      bit succ_ok;
      checks++;
      if (o_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready: got %b expected 1", tag, o_ready);
      end
      v = 1'b1; p = 1'b1; l = 1'b1;
      tick();
      v = 1'b0; l = 1'b0;
      n = 1;   // the write edge counts as edge 1
      while (o_nt !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (n !== 10) begin
         errors++;
         $display("FAIL %s latency: got %0d expected 10", tag, n);
      end
      checks++;
      if (o_succ !== 1'b1) begin
         errors++;
         $display("FAIL %s success_at_rise: got %b expected 1", tag, o_succ);
      end
      w = 1; succ_ok = 1;
      while (o_nt === 1'b1 && w < 40) begin
         tick();
         if (o_nt === 1'b1) w++;
         if (o_succ !== 1'b1) succ_ok = 0;
      end
      checks++;
      if (w !== 16) begin
         errors++;
         $display("FAIL %s pulse_width: got %0d expected 16", tag, w);
      end
      checks++;
      if (succ_ok !== 1'b1) begin
         errors++;
         $display("FAIL %s success_held: got %b expected 1", tag, succ_ok);
      end
      g = 0;
      while (o_done !== 1'b1 && g < 40) begin
         tick();
         g++;
      end
      checks++;
      if (g !== 16) begin
         errors++;
         $display("FAIL %s done_after_gap: got %0d expected 16", tag, g);
      end
      checks++;
      if ({o_pc, o_fc} !== {8'd1, 8'd0}) begin
         errors++;
         $display("FAIL %s counts: got pass=%0d fail=%0d expected pass=1 fail=0", tag, o_pc, o_fc);
      end
      checks++;
      if ({o_sticky, o_busy} !== 2'b00) begin
         errors++;
         $display("FAIL %s sticky_busy: got %b expected 00", tag, {o_sticky, o_busy});
      end
   endtask

   task automatic test_single();
      sel = 1'b0;
      #1;
      single_pass("single");
   endtask

   task automatic test_stop_on_fail();
      logic [2:0] obs;
      sel = 1'b0;
      #1;
      do_reset();
      run_burst(6, 6'b111011, 400);
      for (int i = 0; i < 3; i++) obs[i] = rise_succ[i];
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL sof_timeout: got %b expected 0", timeout);
      end
      checks++;
      if (ready_dropped !== 1'b1) begin
         errors++;
         $display("FAIL sof_ready_drop: got %b expected 1", ready_dropped);
      end
      checks++;
      if (nrise !== 3) begin
         errors++;
         $display("FAIL sof_pulses: got %0d expected 3", nrise);
      end
      checks++;
      if (obs !== 3'b011) begin
         errors++;
         $display("FAIL sof_success_seq: got %b expected 011 (first pulse in bit 0)", obs);
      end
      checks++;
      if (bad_width !== 0) begin
         errors++;
         $display("FAIL sof_width: got %0d bad pulses expected 0", bad_width);
      end
      checks++;
      if ({o_sticky, o_pc, o_fc} !== {1'b1, 8'd2, 8'd1}) begin
         errors++;
         $display("FAIL sof_counts: got sticky=%b pass=%0d fail=%0d expected sticky=1 pass=2 fail=1",
                  o_sticky, o_pc, o_fc);
      end
      checks++;
      if ({o_busy, o_done} !== 2'b00) begin
         errors++;
         $display("FAIL sof_drained: got busy/done=%b expected 00", {o_busy, o_done});
      end
   endtask

   task automatic test_no_stop();
      logic [5:0] obs;
      int         bad_gap;
      sel = 1'b1;
      #1;
      do_reset();
      run_burst(6, 6'b111011, 400);
      bad_gap = 0;
      for (int i = 0; i < 6; i++) obs[i] = rise_succ[i];
      for (int i = 0; i < 5; i++) if (rise_cyc[i+1] - rise_cyc[i] != 41) bad_gap++;
      checks++;
      if (timeout !== 1'b0) begin
         errors++;
         $display("FAIL nostop_timeout: got %b expected 0", timeout);
      end
      checks++;
      if (nrise !== 6) begin
         errors++;
         $display("FAIL nostop_pulses: got %0d expected 6", nrise);
      end
      checks++;
      if (obs !== 6'b111011) begin
         errors++;
         $display("FAIL nostop_success_seq: got %b expected 111011", obs);
      end
      checks++;
      if (bad_gap !== 0) begin
         errors++;
         $display("FAIL nostop_period: got %0d gaps not 41 (first gap %0d) expected 0",
                  bad_gap, rise_cyc[1] - rise_cyc[0]);
      end
      checks++;
      if ({o_pc, o_fc} !== {8'd5, 8'd1}) begin
         errors++;
         $display("FAIL nostop_counts: got pass=%0d fail=%0d expected pass=5 fail=1", o_pc, o_fc);
      end
      checks++;
      if (bad_width !== 0) begin
         errors++;
         $display("FAIL nostop_width: got %0d bad pulses expected 0", bad_width);
      end
   endtask

   // Sixth push lands on the edge the full FIFO pops its head.
   task automatic test_pop_push_full();
      logic [5:0] obs;
      sel = 1'b1;
      #1;
      do_reset();
      run_burst(6, 6'b101001, 400);
      for (int i = 0; i < 6; i++) obs[i] = rise_succ[i];
      checks++;
      if (nxfer !== 6) begin
         errors++;
         $display("FAIL full_pop_xfers: got %0d expected 6", nxfer);
      end
      checks++;
      if (xfer_cyc[5] - xfer_cyc[0] !== 42) begin
         errors++;
         $display("FAIL full_pop_xfer_time: got %0d expected 42", xfer_cyc[5] - xfer_cyc[0]);
      end
      checks++;
      if ({rdy_after[4], rdy_after[5]} !== 2'b00) begin
         errors++;
         $display("FAIL full_pop_still_full: got %b expected 00", {rdy_after[4], rdy_after[5]});
      end
      checks++;
      if (obs !== 6'b101001) begin
         errors++;
         $display("FAIL full_pop_order: got %b expected 101001", obs);
      end
      checks++;
      if ({o_pc, o_fc} !== {8'd3, 8'd3}) begin
         errors++;
         $display("FAIL full_pop_counts: got pass=%0d fail=%0d expected pass=3 fail=3", o_pc, o_fc);
      end
   endtask

   task automatic test_reset_mid_pulse();
      int n;
      sel = 1'b1;
      #1;
      do_reset();
      v = 1'b1; p = 1'b1; l = 1'b0;
      tick();
      v = 1'b0;
      n = 0;
      while (o_nt !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      checks++;
      if (o_nt !== 1'b1) begin
         errors++;
         $display("FAIL midrst_reach_pulse: got %b expected 1", o_nt);
      end
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      checks++;
      if ({o_nt, o_succ, o_busy, o_ready} !== 4'b0000) begin
         errors++;
         $display("FAIL midrst_outputs: got %b expected 0000", {o_nt, o_succ, o_busy, o_ready});
      end
      checks++;
      if ({o_pc, o_fc} !== 16'h0) begin
         errors++;
         $display("FAIL midrst_counts: got %h expected 0000", {o_pc, o_fc});
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if ({o_ready, o_nt} !== 2'b10) begin
         errors++;
         $display("FAIL midrst_release: got ready/nt=%b expected 10", {o_ready, o_nt});
      end
      single_pass("after_reset");
   endtask

   task automatic test_after_done();
      bit seen;
      sel = 1'b1;
      #1;
      v = 1'b1; p = 1'b1; l = 1'b0;
      tick();
      v = 1'b0;
      seen = 0;
      repeat (60) begin
         tick();
         if (o_nt === 1'b1) seen = 1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL after_done_pulse: got %b expected 0", seen);
      end
      checks++;
      if ({o_pc, o_fc} !== {8'd1, 8'd0}) begin
         errors++;
         $display("FAIL after_done_counts: got pass=%0d fail=%0d expected pass=1 fail=0", o_pc, o_fc);
      end
      checks++;
      if ({o_done, o_busy, o_succ} !== 3'b101) begin
         errors++;
         $display("FAIL after_done_flags: got done/busy/success=%b expected 101", {o_done, o_busy, o_succ});
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      v = 1'b0; p = 1'b0; l = 1'b0;
      sel = 1'b0;
      test_reset();
      test_single();
      test_stop_on_fail();
      test_no_stop();
      test_pop_push_full();
      test_reset_mid_pulse();
      test_after_done();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
